disp_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one hexadecimal 7-segment decoder among four common-anode digits. Each frame it latches a 16-bit value and steps through digits 0..3, with a programmable display slot and an optional blanking gap between digits to suppress ghosting. It drives the nibble into deco7seg_hexa and generates the active-low anode enables and the decimal-point output. Optional leading-zero blanking is provided.

---
 rtl/disp_pkg.sv | 16 +
 rtl/disp_scan_ctrl_tick.sv | 20 ++
 rtl/disp_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package disp_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;

  localparam int         N_DIG  = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [N_DIG-1:0] an_onehot_n(input logic [1:0] idx);
    logic [N_DIG-1:0] an;
    an      = AN_OFF;
    an[idx] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_tick.sv
// Scan-rate prescaler: emits a one-cycle enable pulse every 2^DIV_BITS clocks.
module scan_tick_gen #(
  parameter int DIV_BITS = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic tick
);

  logic [DIV_BITS-1:0] cntQ;

  always_ff @(posedge CLK) begin
    if (!RST || CLR) cntQ <= '0;
    else             cntQ <= cntQ + DIV_BITS'(1);
  end

  assign tick = !CLR && (cntQ == '1);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit common-anode scanner sharing one hex 7-segment decoder,
// with per-frame shadowing of the value, blanking gaps and leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIV_BITS    = 10,
  parameter int SHOW_TICKS  = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [15:0] VAL,
  input  logic [3:0]  DP,
  input  logic        LZB,
  output logic [3:0]  NIB,
  output logic [3:0]  AN,
  output logic        DP_N,
  output logic [1:0]  DIG,
  output logic        FRAME
);

  localparam int MAX_TICKS = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int SLOT_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [SLOT_W-1:0] SHOW_LAST  = SLOT_W'(SHOW_TICKS - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  scan_state_t       stateQ, stateD;
  logic [1:0]        digQ, digD;
  logic [SLOT_W-1:0] slotQ, slotD;
  logic [15:0]       shadowValQ, shadowValD;
  logic [3:0]        shadowDpQ, shadowDpD;
  logic [3:0]        nibQ, nibD;
  logic [3:0]        anQ, anD;
  logic              dpNQ, dpND;
  logic              frameQ, frameD;
  logic              enterShow;
  logic              upperZero;
  logic              suppress;
  logic              tick;

  scan_tick_gen #(.DIV_BITS(DIV_BITS)) uTick (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  ((stateQ == IDLE) || !EN),
    .tick (tick)
  );

  always_comb begin
    stateD    = stateQ;
    digD      = digQ;
    slotD     = slotQ;
    enterShow = 1'b0;
    case (stateQ)
      IDLE: begin
        if (EN) begin
          stateD    = SHOW;
          digD      = 2'd0;
          slotD     = '0;
          enterShow = 1'b1;
        end
      end
      SHOW: begin
        if (tick) begin
          if (slotQ == SHOW_LAST) begin
            slotD = '0;
            if (BLANK_TICKS > 0) begin
              stateD = BLANK;
            end else begin
              digD      = digQ + 2'd1;
              enterShow = 1'b1;
            end
          end else begin
            slotD = slotQ + SLOT_W'(1);
          end
        end
      end
      BLANK: begin
        if (tick) begin
          if (slotQ == BLANK_LAST) begin
            slotD     = '0;
            stateD    = SHOW;
            digD      = digQ + 2'd1;
            enterShow = 1'b1;
          end else begin
            slotD = slotQ + SLOT_W'(1);
          end
        end
      end
      default: stateD = IDLE;
    endcase
    if (!EN) begin
      stateD    = IDLE;
      digD      = 2'd0;
      slotD     = '0;
      enterShow = 1'b0;
    end
  end

  // Outputs are precomputed from next-state values so they can be registered.
  always_comb begin
    shadowValD = shadowValQ;
    shadowDpD  = shadowDpQ;
    if (enterShow && (digD == 2'd0)) begin
      shadowValD = VAL;
      shadowDpD  = DP;
    end
    upperZero = 1'b1;
    for (int i = 0; i < N_DIG; i++) begin
      if ((i >= int'(digD)) && (shadowValD[4*i +: 4] != 4'h0)) upperZero = 1'b0;
    end
    suppress = LZB && (digD != 2'd0) && upperZero;
    nibD     = (stateD == SHOW) ? shadowValD[{digD, 2'b00} +: 4] : nibQ;
    anD      = ((stateD == SHOW) && !suppress) ? an_onehot_n(digD) : AN_OFF;
    dpND     = ((stateD == SHOW) && !suppress) ? ~shadowDpD[digD] : 1'b1;
    frameD   = enterShow && (digD == 2'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stateQ     <= IDLE;
      digQ       <= 2'd0;
      slotQ      <= '0;
      shadowValQ <= '0;
      shadowDpQ  <= '0;
      nibQ       <= '0;
      anQ        <= AN_OFF;
      dpNQ       <= 1'b1;
      frameQ     <= 1'b0;
    end else begin
      stateQ     <= stateD;
      digQ       <= digD;
      slotQ      <= slotD;
      shadowValQ <= shadowValD;
      shadowDpQ  <= shadowDpD;
      nibQ       <= nibD;
      anQ        <= anD;
      dpNQ       <= dpND;
      frameQ     <= frameD;
    end
  end

  assign NIB   = nibQ;
  assign AN    = anQ;
  assign DP_N  = dpNQ;
  assign DIG   = digQ;
  assign FRAME = frameQ;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Table-driven bench: span records expand to per-cycle expectations queued on drive, checked after the edge.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstA, enA, rstB, enB;
  logic [15:0] val;
  logic [3:0]  dp;
  logic        lzb;
  logic [3:0]  nibA, anA, nibB, anB;
  logic        dpnA, dpnB, frameA, frameB;
  logic [1:0]  digA, digB;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIV_BITS(2), .SHOW_TICKS(2), .BLANK_TICKS(1)) dutA (
    .CLK(clk), .RST(rstA), .EN(enA), .VAL(val), .DP(dp), .LZB(lzb),
    .NIB(nibA), .AN(anA), .DP_N(dpnA), .DIG(digA), .FRAME(frameA)
  );

  disp_scan_ctrl #(.DIV_BITS(2), .SHOW_TICKS(2), .BLANK_TICKS(0)) dutB (
    .CLK(clk), .RST(rstB), .EN(enB), .VAL(val), .DP(dp), .LZB(lzb),
    .NIB(nibB), .AN(anB), .DP_N(dpnB), .DIG(digB), .FRAME(frameB)
  );

  typedef struct {
    bit          sel;
    bit          rst;
    bit          en;
    logic [15:0] val;
    logic [3:0]  dp;
    bit          lzb;
    int          n;
    logic [3:0]  an;
    logic [3:0]  nib;
    bit          dpn;
    logic [1:0]  dig;
    bit          frame;
  } vec_t;

  typedef struct {
    bit          sel;
    int          row;
    logic [11:0] want;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vecCount  = 0;
  int   missCount = 0;

  function automatic void addRow(bit sel, bit rst, bit en, logic [15:0] v, logic [3:0] d, bit l,
                                 int n, logic [3:0] an, logic [3:0] nib, bit dpn,
                                 logic [1:0] dig, bit frame);
    vec_t r;
    r.sel = sel; r.rst = rst; r.en = en; r.val = v; r.dp = d; r.lzb = l; r.n = n;
    r.an = an; r.nib = nib; r.dpn = dpn; r.dig = dig; r.frame = frame;
    vecs.push_back(r);
  endfunction

  // One digit slot: 8 lit cycles (first one carries FRAME when it opens a frame), then the gap.
  function automatic void addSlot(bit sel, logic [15:0] v, logic [3:0] d, bit l,
                                  logic [3:0] an, logic [3:0] nib, bit dpn, logic [1:0] dig,
                                  bit first, int blankN);
    if (first) begin
      addRow(sel, 1, 1, v, d, l, 1, an, nib, dpn, dig, 1);
      addRow(sel, 1, 1, v, d, l, 7, an, nib, dpn, dig, 0);
    end else begin
      addRow(sel, 1, 1, v, d, l, 8, an, nib, dpn, dig, 0);
    end
    if (blankN > 0) addRow(sel, 1, 1, v, d, l, blankN, 4'hF, nib, 1, dig, 0);
  endfunction

  task automatic applyStimulus(input vec_t r, input int row);
    exp_t e;
    val = r.val;
    dp  = r.dp;
    lzb = r.lzb;
    if (r.sel) begin
      rstA = 1'b0; enA = 1'b0; rstB = r.rst; enB = r.en;
    end else begin
      rstA = r.rst; enA = r.en; rstB = 1'b0; enB = 1'b0;
    end
    e.sel  = r.sel;
    e.row  = row;
    e.want = {r.an, r.nib, r.dpn, r.dig, r.frame};
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [11:0] got;
    vecCount++;
    if (sb.size() == 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard: got empty queue, want a pending expectation");
      return;
    end
    e   = sb.pop_front();
    got = e.sel ? {anB, nibB, dpnB, digB, frameB} : {anA, nibA, dpnA, digA, frameA};
    if (got !== e.want) begin
      missCount++;
      $display("[TB] FAIL row%0d dut%s t=%0t: got an=%b nib=%h dpn=%b dig=%0d frame=%b, want an=%b nib=%h dpn=%b dig=%0d frame=%b",
               e.row, e.sel ? "B" : "A", $time,
               got[11:8], got[7:4], got[3], got[2:1], got[0],
               e.want[11:8], e.want[7:4], e.want[3], e.want[2:1], e.want[0]);
    end
  endtask

  initial begin
    rstA = 1'b0; enA = 1'b0; rstB = 1'b0; enB = 1'b0;
    val = '0; dp = '0; lzb = 1'b0;

    addRow(0, 0, 1, 16'h1234, 4'b0100, 0, 4, 4'hF, 4'h0, 1, 2'd0, 0);
    addSlot(0, 16'h1234, 4'b0100, 0, 4'hE, 4'h4, 1, 2'd0, 1, 4);
    addSlot(0, 16'h1234, 4'b0100, 0, 4'hD, 4'h3, 1, 2'd1, 0, 4);
    addSlot(0, 16'h1234, 4'b0100, 0, 4'hB, 4'h2, 0, 2'd2, 0, 4);
    addSlot(0, 16'h1234, 4'b0100, 0, 4'h7, 4'h1, 1, 2'd3, 0, 4);

    addSlot(0, 16'h1234, 4'b0100, 0, 4'hE, 4'h4, 1, 2'd0, 1, 4);
    addRow(0, 1, 1, 16'h1234, 4'b0100, 0, 4, 4'hD, 4'h3, 1, 2'd1, 0);
    addRow(0, 1, 1, 16'hABCD, 4'b0001, 0, 4, 4'hD, 4'h3, 1, 2'd1, 0);
    addRow(0, 1, 1, 16'hABCD, 4'b0001, 0, 4, 4'hF, 4'h3, 1, 2'd1, 0);
    addSlot(0, 16'hABCD, 4'b0001, 0, 4'hB, 4'h2, 0, 2'd2, 0, 4);
    addSlot(0, 16'hABCD, 4'b0001, 0, 4'h7, 4'h1, 1, 2'd3, 0, 4);

    addSlot(0, 16'hABCD, 4'b0001, 0, 4'hE, 4'hD, 0, 2'd0, 1, 4);
    addSlot(0, 16'hABCD, 4'b0001, 0, 4'hD, 4'hC, 1, 2'd1, 0, 4);
    addSlot(0, 16'hABCD, 4'b0001, 0, 4'hB, 4'hB, 1, 2'd2, 0, 4);
    addSlot(0, 16'hABCD, 4'b0001, 0, 4'h7, 4'hA, 1, 2'd3, 0, 4);

    addSlot(0, 16'h0050, 4'b0000, 1, 4'hE, 4'h0, 1, 2'd0, 1, 4);
    addSlot(0, 16'h0050, 4'b0000, 1, 4'hD, 4'h5, 1, 2'd1, 0, 4);
    addSlot(0, 16'h0050, 4'b0000, 1, 4'hF, 4'h0, 1, 2'd2, 0, 4);
    addSlot(0, 16'h0050, 4'b0000, 1, 4'hF, 4'h0, 1, 2'd3, 0, 4);

    addSlot(0, 16'h0000, 4'b0000, 1, 4'hE, 4'h0, 1, 2'd0, 1, 4);
    addSlot(0, 16'h0000, 4'b0000, 1, 4'hF, 4'h0, 1, 2'd1, 0, 4);
    addSlot(0, 16'h0000, 4'b0000, 1, 4'hF, 4'h0, 1, 2'd2, 0, 4);
    addSlot(0, 16'h0000, 4'b0000, 1, 4'hF, 4'h0, 1, 2'd3, 0, 4);

    addSlot(0, 16'h1234, 4'b0100, 0, 4'hE, 4'h4, 1, 2'd0, 1, 4);
    addSlot(0, 16'h1234, 4'b0100, 0, 4'hD, 4'h3, 1, 2'd1, 0, 4);
    addRow(0, 1, 1, 16'h1234, 4'b0100, 0, 3, 4'hB, 4'h2, 0, 2'd2, 0);
    addRow(0, 1, 0, 16'h1234, 4'b0100, 0, 3, 4'hF, 4'h2, 1, 2'd0, 0);
    addSlot(0, 16'h1234, 4'b0100, 0, 4'hE, 4'h4, 1, 2'd0, 1, 4);

    addRow(1, 0, 1, 16'h1234, 4'b0100, 0, 2, 4'hF, 4'h0, 1, 2'd0, 0);
    addSlot(1, 16'h1234, 4'b0100, 0, 4'hE, 4'h4, 1, 2'd0, 1, 0);
    addSlot(1, 16'h1234, 4'b0100, 0, 4'hD, 4'h3, 1, 2'd1, 0, 0);
    addSlot(1, 16'h1234, 4'b0100, 0, 4'hB, 4'h2, 0, 2'd2, 0, 0);
    addSlot(1, 16'h1234, 4'b0100, 0, 4'h7, 4'h1, 1, 2'd3, 0, 0);
    addRow(1, 1, 1, 16'h1234, 4'b0100, 0, 1, 4'hE, 4'h4, 1, 2'd0, 1);
    addRow(1, 1, 1, 16'h1234, 4'b0100, 0, 3, 4'hE, 4'h4, 1, 2'd0, 0);
    addRow(1, 0, 1, 16'h1234, 4'b0100, 0, 1, 4'hF, 4'h0, 1, 2'd0, 0);
    addSlot(1, 16'h1234, 4'b0100, 0, 4'hE, 4'h4, 1, 2'd0, 1, 0);
    addRow(1, 1, 1, 16'h1234, 4'b0100, 0, 1, 4'hD, 4'h3, 1, 2'd1, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        applyStimulus(vecs[i], i);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
